// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the encoder velocity estimator.
// FILT exists only when ENC_VEL_AVG_EN is defined.
package enc_pkg;

  localparam int unsigned POS_W = 32;
  localparam int unsigned VEL_W = 32;

`ifdef ENC_VEL_AVG_EN
  typedef enum logic [2:0] {IDLE, ARM, RUN, CALC, FILT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, RUN, CALC} state_t;
`endif

endpackage

// File: rtl/enc_vel_avg4.sv
// 4-tap moving average of velocity deltas; built only when ENC_VEL_AVG_EN is defined.
// Output is combinational from the history, rounding toward -inf.
`ifdef ENC_VEL_AVG_EN
module enc_vel_avg4
  import enc_pkg::*;
(
  input  logic                    clk,
  input  logic                    Clr,
  input  logic                    clr,
  input  logic                    push,
  input  logic signed [VEL_W-1:0] din,
  output logic signed [VEL_W-1:0] avg
);

  logic signed [VEL_W-1:0] hist_q [4];
  logic        [VEL_W+1:0] sum;

  always_ff @(posedge clk or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (push) begin
      hist_q[0] <= din;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  always_comb begin
    sum = {{2{hist_q[0][VEL_W-1]}}, hist_q[0]} + {{2{hist_q[1][VEL_W-1]}}, hist_q[1]}
        + {{2{hist_q[2][VEL_W-1]}}, hist_q[2]} + {{2{hist_q[3][VEL_W-1]}}, hist_q[3]};
    // Dropping the two LSBs of the sign-extended sum is an arithmetic shift by 2.
    avg = sum[VEL_W+1:2];
  end

endmodule
`endif

// File: rtl/enc_vel_est.sv
// Encoder velocity estimator: position delta per PERIOD_CYC clocks with valid/ready output.
// Define ENC_VEL_AVG_EN to add a 4-tap moving average (one extra cycle latency).
module enc_vel_est
  import enc_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = 100000,
  parameter int unsigned STALL_N    = 8
) (
  input  logic                    clk,
  input  logic                    Clr,
  input  logic                    en,
  input  logic signed [POS_W-1:0] pos,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  input  logic                    vel_ready,
  output logic                    stall,
  output logic                    overrun
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
  localparam int unsigned ZC_W  = $clog2(STALL_N + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(PERIOD_CYC - 1);
  localparam logic [ZC_W-1:0]  ZC_MAX = ZC_W'(STALL_N);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [POS_W-1:0] pos_prev_q;
  logic signed [POS_W-1:0] pos_now_q;
  logic [ZC_W-1:0]         zcnt_q;
  logic [ZC_W-1:0]         zcnt_nxt;
  logic signed [VEL_W-1:0] delta;
  logic                    tc;

  always_comb begin
    tc = (cnt_q == CNT_TC);
    // Modulo subtraction keeps the delta correct across the signed position wrap.
    delta = pos_now_q - pos_prev_q;
    zcnt_nxt = '0;
    if (delta == '0) zcnt_nxt = (zcnt_q == ZC_MAX) ? zcnt_q : zcnt_q + ZC_W'(1);
  end

`ifdef ENC_VEL_AVG_EN
  logic signed [VEL_W-1:0] avg;

  enc_vel_avg4 u_avg (
    .clk  (clk),
    .Clr  (Clr),
    .clr  (state_q == IDLE),
    .push (state_q == CALC),
    .din  (delta),
    .avg  (avg)
  );
`endif

  always_ff @(posedge clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pos_prev_q <= '0;
      pos_now_q  <= '0;
      zcnt_q     <= '0;
      vel        <= '0;
      vel_valid  <= 1'b0;
      stall      <= 1'b0;
      overrun    <= 1'b0;
    end else if (!en) begin
      // vel deliberately holds its last value.
      state_q   <= IDLE;
      cnt_q     <= '0;
      zcnt_q    <= '0;
      vel_valid <= 1'b0;
      stall     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // The period counter keeps running through CALC/FILT so periods abut.
      cnt_q <= (state_q == IDLE || tc) ? '0 : cnt_q + CNT_W'(1);
      if (vel_ready) vel_valid <= 1'b0;
      case (state_q)
        IDLE: state_q <= ARM;
        ARM: begin
          if (tc) begin
            pos_prev_q <= pos;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (tc) begin
            pos_now_q <= pos;
            state_q   <= CALC;
          end
        end
        CALC: begin
          pos_prev_q <= pos_now_q;
          zcnt_q     <= zcnt_nxt;
`ifdef ENC_VEL_AVG_EN
          state_q    <= FILT;
        end
        FILT: begin
          state_q   <= RUN;
          vel       <= avg;
          stall     <= (zcnt_q == ZC_MAX);
          vel_valid <= 1'b1;
          if (vel_valid && !vel_ready) overrun <= 1'b1;
        end
`else
          state_q    <= RUN;
          vel        <= delta;
          stall      <= (zcnt_nxt == ZC_MAX);
          vel_valid  <= 1'b1;
          if (vel_valid && !vel_ready) overrun <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_vel_est.sv
// Directed bench for enc_vel_est with PERIOD_CYC=10, STALL_N=8.
// Expectations switch with ENC_VEL_AVG_EN.
module tb_enc_vel_est;

`ifdef ENC_VEL_AVG_EN
  localparam int LAT = 3;
  localparam logic [31:0] D1 = 32'd10;
  localparam logic [31:0] D2 = 32'd30;
  localparam logic [31:0] RST_EV = 32'hFFFF_FFFE;
`else
  localparam int LAT = 2;
  localparam logic [31:0] D1 = 32'd40;
  localparam logic [31:0] D2 = 32'd80;
  localparam logic [31:0] RST_EV = 32'hFFFF_FFF9;
`endif

  logic               clk = 1'b0;
  logic               Clr;
  logic               en;
  logic signed [31:0] pos;
  logic signed [31:0] vel;
  logic               vel_valid;
  logic               vel_ready;
  logic               stall;
  logic               overrun;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pv;
    bit          ramp;
    logic [31:0] ev;
    logic        es;
  } vec_t;

  vec_t tab[$];

  enc_vel_est #(
    .PERIOD_CYC (10),
    .STALL_N    (8)
  ) dut (
    .clk       (clk),
    .Clr       (Clr),
    .en        (en),
    .pos       (pos),
    .vel       (vel),
    .vel_valid (vel_valid),
    .vel_ready (vel_ready),
    .stall     (stall),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pv, input bit ramp, input logic [31:0] ev, input logic es);
    vec_t v;
    v.pv = pv;
    v.ramp = ramp;
    v.ev = ev;
    v.es = es;
    tab.push_back(v);
  endtask

  // One 10-cycle period starting at the negedge after a terminal count. Checks the sample
  // latched at the end of the previous period.
  task automatic win(input logic [31:0] pv, input bit ramp, input bit chk, input logic pre_v,
                     input logic [31:0] ev, input logic es, input logic eo, input logic rdy_end);
    logic v_lat;
    v_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (chk) begin
        if (i < LAT - 1) check("pre_valid", {31'b0, vel_valid}, {31'b0, pre_v});
        if (i == LAT - 1) begin
          check("valid", {31'b0, vel_valid}, 32'd1);
          check("vel", vel, ev);
          check("stall", {31'b0, stall}, {31'b0, es});
          check("overrun", {31'b0, overrun}, {31'b0, eo});
          v_lat = !vel_ready;
        end
        if (i == LAT) begin
          check("valid_after_ready", {31'b0, vel_valid}, {31'b0, v_lat});
          v_lat = v_lat && !rdy_end;
          vel_ready = rdy_end;
        end
        if (i == LAT + 1) begin
          check("valid_hold", {31'b0, vel_valid}, {31'b0, v_lat});
          check("overrun_hold", {31'b0, overrun}, {31'b0, eo});
        end
      end
      if (i == 0) pos = pv;
      else if (ramp) pos = pos + 1;
    end
  endtask

  initial begin
    vec_t pr;
    Clr = 1'b0;
    en = 1'b1;
    vel_ready = 1'b1;
    pos = 32'sd0;

`ifdef ENC_VEL_AVG_EN
    add(32'd0, 1'b0, 32'd0, 1'b0);
    add(32'd4, 1'b0, 32'd1, 1'b0);
    add(32'd12, 1'b0, 32'd3, 1'b0);
    add(32'd24, 1'b0, 32'd6, 1'b0);
    add(32'd40, 1'b0, 32'd10, 1'b0);
    add(32'd40, 1'b0, 32'd0, 1'b0);
`else
    add(32'd0, 1'b1, 32'd0, 1'b0);
    add(32'd10, 1'b1, 32'd10, 1'b0);
    add(32'd20, 1'b1, 32'd10, 1'b0);
    add(32'd30, 1'b1, 32'd10, 1'b0);
    add(32'h7FFF_FFFE, 1'b0, 32'h7FFF_FFD7, 1'b0);
    add(32'h8000_0008, 1'b0, 32'd10, 1'b0);
    add(32'h7FFF_FFFE, 1'b0, 32'hFFFF_FFF6, 1'b0);
    for (int k = 0; k < 7; k++) add(32'h7FFF_FFFE, 1'b0, 32'd0, 1'b0);
    add(32'h7FFF_FFFE, 1'b0, 32'd0, 1'b1);
    add(32'h8000_0003, 1'b0, 32'd5, 1'b0);
    add(32'h8000_0003, 1'b0, 32'd0, 1'b0);
`endif

    // Reset held with enable and moving position: outputs stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_vel", vel, 32'd0);
      check("rst_flags", {29'b0, vel_valid, stall, overrun}, 32'd0);
      pos = pos + 32'sh1234_5679;
    end
    #2 Clr = 1'b1;

    for (int j = 0; j < tab.size(); j++) begin
      pr = (j > 0) ? tab[j-1] : tab[0];
      win(tab[j].pv, tab[j].ramp, j >= 2, 1'b0, pr.ev, pr.es, 1'b0, 1'b1);
    end

    // Enable drop: flags clear, vel holds.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("endrop_vel", vel, tab[tab.size()-2].ev);
    check("endrop_flags", {29'b0, vel_valid, stall, overrun}, 32'd0);
    en = 1'b1;

    // Restart, then two completions with ready low.
    win(32'd1000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    vel_ready = 1'b0;
    win(32'd1040, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    win(32'd1120, 1'b0, 1'b1, 1'b0, D1, 1'b0, 1'b0, 1'b0);
    win(32'd1120, 1'b0, 1'b1, 1'b1, D2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("endrop2_vel", vel, D2);
    check("endrop2_flags", {29'b0, vel_valid, stall, overrun}, 32'd0);
    en = 1'b1;

    // Asynchronous reset mid-period, then clean restart.
    repeat (4) @(negedge clk);
    #2 Clr = 1'b0;
    #1 check("async_vel", vel, 32'd0);
    check("async_flags", {29'b0, vel_valid, stall, overrun}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      pos = pos + 32'sd77;
    end
    #2 Clr = 1'b1;
    win(32'd5000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    win(32'd4993, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    win(32'd4993, 1'b0, 1'b1, 1'b0, RST_EV, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
